// File: rtl/commit_trace_fifo.sv
// commit_trace_fifo: collects WB/MEM/EX commit events in age order into a FWFT FIFO drained by a checker
// Ports:
//   clk, reset_n                    clock, asynchronous active-low reset
//   wb_*                            register/load writeback tap (x0 writes ignored)
//   st_*                            store tap
//   br_*                            branch/jalr resolution tap
//   out_valid/out_ready, out_*      valid/ready stream of the head entry (fields 0 when empty)
//   overflow, drop_cnt, commit_cnt  sticky drop flag and saturating event counters
module commit_trace_fifo #(
   parameter int DEPTH = 16,
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             wb_valid,
   input  logic             wb_is_load,
   input  logic [31:0]      wb_pc,
   input  logic [31:0]      wb_instr,
   input  logic [4:0]       wb_rd,
   input  logic [31:0]      wb_data,
   input  logic [31:0]      wb_addr,
   input  logic             st_valid,
   input  logic [31:0]      st_pc,
   input  logic [31:0]      st_instr,
   input  logic [31:0]      st_addr,
   input  logic [31:0]      st_data,
   input  logic             br_valid,
   input  logic [31:0]      br_pc,
   input  logic [31:0]      br_instr,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [1:0]       out_type,
   output logic [31:0]      out_pc,
   output logic [31:0]      out_instr,
   output logic [4:0]       out_rd,
   output logic [31:0]      out_value,
   output logic [31:0]      out_addr,
   output logic             overflow,
   output logic [CNT_W-1:0] drop_cnt,
   output logic [CNT_W-1:0] commit_cnt
);
   localparam int AW = $clog2(DEPTH);

   typedef struct packed {
      logic [1:0]  typ;
      logic [31:0] pc;
      logic [31:0] instr;
      logic [4:0]  rd;
      logic [31:0] value;
      logic [31:0] addr;
   } entry_t;

   entry_t           mem_q [DEPTH];
   entry_t           ev [3];
   entry_t           head;
   logic [2:0]       ev_v, wr_en;
   logic [1:0]       pos [3];
   logic [1:0]       n_ev, n_wr, n_drop;
   logic [AW:0]      count_q, count_d, free;
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic             pop;
   logic             overflow_q, overflow_d;
   logic [CNT_W-1:0] drop_q, drop_d, commit_q, commit_d;

   function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] c, input logic [1:0] n);
      logic [CNT_W:0] s;
      s = {1'b0, c} + (CNT_W+1)'(n);
      return s[CNT_W] ? '1 : s[CNT_W-1:0];
   endfunction

   assign out_valid = count_q != '0;

   always_comb begin
      ev_v  = {br_valid, st_valid, wb_valid && (wb_rd != 5'd0)};
      ev[0] = '{typ: wb_is_load ? 2'd2 : 2'd0, pc: wb_pc, instr: wb_instr, rd: wb_rd,
                value: wb_data, addr: wb_is_load ? wb_addr : 32'd0};
      ev[1] = '{typ: 2'd1, pc: st_pc, instr: st_instr, rd: 5'd0, value: st_data, addr: st_addr};
      ev[2] = '{typ: 2'd3, pc: br_pc, instr: br_instr, rd: 5'd0, value: 32'd0, addr: 32'd0};
      // capacity is taken from the start-of-cycle count; a same-cycle pop frees nothing yet
      free   = (AW+1)'(DEPTH) - count_q;
      // pos is each event's slot offset among the qualified events of this cycle
      pos[0] = 2'd0;
      pos[1] = 2'(ev_v[0]);
      pos[2] = 2'(ev_v[0]) + 2'(ev_v[1]);
      for (int i = 0; i < 3; i++) wr_en[i] = ev_v[i] && ((AW+1)'(pos[i]) < free);
      n_ev       = 2'(ev_v[0]) + 2'(ev_v[1]) + 2'(ev_v[2]);
      n_wr       = 2'(wr_en[0]) + 2'(wr_en[1]) + 2'(wr_en[2]);
      n_drop     = n_ev - n_wr;
      pop        = out_valid && out_ready;
      count_d    = count_q + (AW+1)'(n_wr) - (AW+1)'(pop);
      wr_ptr_d   = wr_ptr_q + AW'(n_wr);
      rd_ptr_d   = rd_ptr_q + AW'(pop);
      overflow_d = overflow_q || (n_drop != 2'd0);
      drop_d     = sat_add(drop_q, n_drop);
      commit_d   = sat_add(commit_q, n_wr);
      head       = out_valid ? mem_q[rd_ptr_q] : '0;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count_q    <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         overflow_q <= 1'b0;
         drop_q     <= '0;
         commit_q   <= '0;
      end else begin
         count_q    <= count_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         overflow_q <= overflow_d;
         drop_q     <= drop_d;
         commit_q   <= commit_d;
      end
   end

   // storage is intentionally not reset; the pointers alone define valid contents
   always_ff @(posedge clk) begin
      for (int i = 0; i < 3; i++)
         if (wr_en[i]) mem_q[wr_ptr_q + AW'(pos[i])] <= ev[i];
   end

   assign out_type   = head.typ;
   assign out_pc     = head.pc;
   assign out_instr  = head.instr;
   assign out_rd     = head.rd;
   assign out_value  = head.value;
   assign out_addr   = head.addr;
   assign overflow   = overflow_q;
   assign drop_cnt   = drop_q;
   assign commit_cnt = commit_q;
endmodule

// File: tb/tb_commit_trace_fifo.sv
// tb_commit_trace_fifo: directed self-checking bench for commit_trace_fifo
module tb_commit_trace_fifo;
   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        wb_valid, wb_is_load, st_valid, br_valid, out_ready;
   logic [31:0] wb_pc, wb_instr, wb_data, wb_addr, st_pc, st_instr, st_addr, st_data, br_pc, br_instr;
   logic [4:0]  wb_rd;
   logic        out_valid, overflow;
   logic [1:0]  out_type;
   logic [31:0] out_pc, out_instr, out_value, out_addr, drop_cnt, commit_cnt;
   logic [4:0]  out_rd;
   int          n_chk = 0;
   int          n_fail = 0;

   commit_trace_fifo #(.DEPTH(16), .CNT_W(32)) dut (
      .clk(clk), .reset_n(reset_n),
      .wb_valid(wb_valid), .wb_is_load(wb_is_load), .wb_pc(wb_pc), .wb_instr(wb_instr),
      .wb_rd(wb_rd), .wb_data(wb_data), .wb_addr(wb_addr),
      .st_valid(st_valid), .st_pc(st_pc), .st_instr(st_instr), .st_addr(st_addr), .st_data(st_data),
      .br_valid(br_valid), .br_pc(br_pc), .br_instr(br_instr),
      .out_valid(out_valid), .out_ready(out_ready), .out_type(out_type), .out_pc(out_pc),
      .out_instr(out_instr), .out_rd(out_rd), .out_value(out_value), .out_addr(out_addr),
      .overflow(overflow), .drop_cnt(drop_cnt), .commit_cnt(commit_cnt)
   );

   always #5 clk = ~clk;

   task step;
      @(posedge clk);
      #1;
   endtask

   task idle;
      wb_valid = 0; wb_is_load = 0; st_valid = 0; br_valid = 0;
      wb_pc = 0; wb_instr = 0; wb_rd = 0; wb_data = 0; wb_addr = 0;
      st_pc = 0; st_instr = 0; st_addr = 0; st_data = 0; br_pc = 0; br_instr = 0;
   endtask

   task do_reset;
      idle();
      out_ready = 0;
      reset_n = 0;
      step();
      step();
      reset_n = 1;
   endtask

   task test_reset;
      do_reset();
      n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", out_valid); end
      n_chk++; if ({out_type, out_pc, out_rd, out_value, out_addr} !== '0) begin n_fail++; $display("FAIL reset_data got %h want 0", {out_type, out_pc, out_rd, out_value, out_addr}); end
      n_chk++; if ({overflow, drop_cnt, commit_cnt} !== '0) begin n_fail++; $display("FAIL reset_cnt got %h want 0", {overflow, drop_cnt, commit_cnt}); end
   endtask

   task test_single;
      do_reset();
      wb_valid = 1; wb_rd = 5; wb_data = 32'h2A; wb_pc = 32'h10; wb_instr = 32'h02A00293;
      step();
      idle();
      n_chk++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid got %b want 1", out_valid); end
      n_chk++; if ({out_type, out_rd, out_value, out_pc, out_instr, out_addr} !== {2'd0, 5'd5, 32'h2A, 32'h10, 32'h02A00293, 32'h0})
         begin n_fail++; $display("FAIL single_entry got %h/%h/%h/%h/%h/%h want 0/05/2a/10/02a00293/0", out_type, out_rd, out_value, out_pc, out_instr, out_addr); end
      n_chk++; if (commit_cnt !== 32'd1) begin n_fail++; $display("FAIL single_commit got %0d want 1", commit_cnt); end
   endtask

   task test_x0;
      do_reset();
      wb_valid = 1; wb_rd = 0; wb_data = 32'h55;
      step();
      idle();
      n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL x0_valid got %b want 0", out_valid); end
      n_chk++; if ({commit_cnt, drop_cnt} !== 64'd0) begin n_fail++; $display("FAIL x0_cnt got %0d/%0d want 0/0", commit_cnt, drop_cnt); end
   endtask

   task test_triple;
      do_reset();
      wb_valid = 1; wb_is_load = 1; wb_rd = 6; wb_data = 32'h11; wb_addr = 32'h100;
      st_valid = 1; st_addr = 32'h104; st_data = 32'h22;
      br_valid = 1; br_pc = 32'h40;
      step();
      idle();
      n_chk++; if (commit_cnt !== 32'd3) begin n_fail++; $display("FAIL triple_commit got %0d want 3", commit_cnt); end
      n_chk++; if ({out_valid, out_type, out_rd, out_value, out_addr} !== {1'b1, 2'd2, 5'd6, 32'h11, 32'h100})
         begin n_fail++; $display("FAIL triple_e0 got %b/%0d/%0d/%h/%h want 1/2/6/11/100", out_valid, out_type, out_rd, out_value, out_addr); end
      out_ready = 1;
      step();
      n_chk++; if ({out_valid, out_type, out_rd, out_value, out_addr} !== {1'b1, 2'd1, 5'd0, 32'h22, 32'h104})
         begin n_fail++; $display("FAIL triple_e1 got %b/%0d/%0d/%h/%h want 1/1/0/22/104", out_valid, out_type, out_rd, out_value, out_addr); end
      step();
      n_chk++; if ({out_valid, out_type, out_pc, out_rd, out_value, out_addr} !== {1'b1, 2'd3, 32'h40, 5'd0, 32'h0, 32'h0})
         begin n_fail++; $display("FAIL triple_e2 got %b/%0d/%h/%0d/%h/%h want 1/3/40/0/0/0", out_valid, out_type, out_pc, out_rd, out_value, out_addr); end
      step();
      n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL triple_empty got %b want 0", out_valid); end
      out_ready = 0;
   endtask

   task test_overflow;
      do_reset();
      for (int i = 0; i < 15; i++) begin
         br_valid = 1; br_pc = 32'(i * 4);
         step();
      end
      idle();
      n_chk++; if ({commit_cnt, overflow} !== {32'd15, 1'b0}) begin n_fail++; $display("FAIL ovf_pre got %0d/%b want 15/0", commit_cnt, overflow); end
      wb_valid = 1; wb_rd = 3; wb_data = 32'h33; st_valid = 1; st_data = 32'h44; br_valid = 1;
      step();
      idle();
      n_chk++; if ({commit_cnt, drop_cnt, overflow} !== {32'd16, 32'd2, 1'b1})
         begin n_fail++; $display("FAIL ovf_drop got %0d/%0d/%b want 16/2/1", commit_cnt, drop_cnt, overflow); end
      br_valid = 1;
      step();
      idle();
      n_chk++; if ({commit_cnt, drop_cnt} !== {32'd16, 32'd3}) begin n_fail++; $display("FAIL ovf_full got %0d/%0d want 16/3", commit_cnt, drop_cnt); end
      out_ready = 1;
      for (int i = 0; i < 15; i++) step();
      n_chk++; if ({out_valid, out_type, out_rd, out_value} !== {1'b1, 2'd0, 5'd3, 32'h33})
         begin n_fail++; $display("FAIL ovf_last got %b/%0d/%0d/%h want 1/0/3/33", out_valid, out_type, out_rd, out_value); end
      step();
      n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_empty got %b want 0", out_valid); end
      out_ready = 0;
   endtask

   task test_full_pop;
      int pops;
      logic [1:0] last;
      do_reset();
      for (int i = 0; i < 16; i++) begin
         br_valid = 1;
         step();
      end
      idle();
      out_ready = 1; st_valid = 1; st_data = 32'h77;
      step();
      idle();
      out_ready = 0;
      n_chk++; if ({commit_cnt, drop_cnt, out_valid} !== {32'd16, 32'd1, 1'b1})
         begin n_fail++; $display("FAIL fp_drop got %0d/%0d/%b want 16/1/1", commit_cnt, drop_cnt, out_valid); end
      st_valid = 1; st_data = 32'h88;
      step();
      idle();
      n_chk++; if ({commit_cnt, drop_cnt} !== {32'd17, 32'd1}) begin n_fail++; $display("FAIL fp_accept got %0d/%0d want 17/1", commit_cnt, drop_cnt); end
      out_ready = 1;
      pops = 0;
      last = 0;
      for (int i = 0; i < 20 && out_valid; i++) begin
         last = out_type;
         pops++;
         step();
      end
      out_ready = 0;
      n_chk++; if (pops !== 16) begin n_fail++; $display("FAIL fp_count got %0d want 16", pops); end
      n_chk++; if (last !== 2'd1) begin n_fail++; $display("FAIL fp_last got %0d want 1", last); end
   endtask

   task test_reset_mid;
      do_reset();
      for (int i = 0; i < 5; i++) begin
         wb_valid = 1; wb_rd = 5'(i + 1); wb_data = 32'(i);
         step();
      end
      idle();
      #2;
      reset_n = 0;
      #1;
      n_chk++; if ({out_valid, commit_cnt, drop_cnt, overflow} !== '0)
         begin n_fail++; $display("FAIL rm_async got %b/%0d/%0d/%b want 0/0/0/0", out_valid, commit_cnt, drop_cnt, overflow); end
      step();
      reset_n = 1;
      wb_valid = 1; wb_rd = 7; wb_data = 32'h99;
      step();
      idle();
      n_chk++; if ({out_valid, out_rd, out_value, commit_cnt} !== {1'b1, 5'd7, 32'h99, 32'd1})
         begin n_fail++; $display("FAIL rm_new got %b/%0d/%h/%0d want 1/7/99/1", out_valid, out_rd, out_value, commit_cnt); end
      out_ready = 1;
      step();
      n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rm_sole got %b want 0", out_valid); end
      out_ready = 0;
   endtask

   initial begin
      idle();
      out_ready = 0;
      test_reset();
      test_single();
      test_x0();
      test_triple();
      test_overflow();
      test_full_pop();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/commit_trace_fifo.md
Name: commit_trace_fifo

Overview:
Synthesizable retirement-trace collector that sits between the pipelined core and the commit checker. It captures per-cycle commit events from three taps:
- WB (MEMWB register/load writes)
- MEM (EXMEM stores)
- EX (branch/jalr resolution)

It orders them oldest-first and buffers them in a FIFO. The checker drains the FIFO over a valid/ready stream, which decouples the checker from pipeline timing and from multiple commits in one cycle.

Parameters:
DEPTH, 16, FIFO entries; power of 2, minimum 4.
CNT_W, 32, width of the commit and drop counters.

Ports:
clk  in  1  core clock
reset_n  in  1  asynchronous active-low reset
wb_valid  in  1  WB-stage register write this cycle
wb_is_load  in  1  WB write originates from a load
wb_pc  in  32  PC of WB instruction
wb_instr  in  32  instruction word at WB
wb_rd  in  5  destination register
wb_data  in  32  value written to rd
wb_addr  in  32  load effective address (ignored unless wb_is_load)
st_valid  in  1  store executing in MEM this cycle
st_pc  in  32  PC of store
st_instr  in  32  store instruction word
st_addr  in  32  store byte address
st_data  in  32  store data
br_valid  in  1  branch or jalr resolved this cycle
br_pc  in  32  PC of branch/jalr
br_instr  in  32  branch/jalr instruction word
out_valid  out  1  head entry available
out_ready  in  1  checker accepts head entry
out_type  out  2  0=reg, 1=store, 2=load, 3=branch/jalr
out_pc  out  32  head PC
out_instr  out  32  head instruction
out_rd  out  5  head rd (0 for store/branch)
out_value  out  32  reg/load value or store data (0 for branch)
out_addr  out  32  load/store address (0 otherwise)
overflow  out  1  sticky: at least one event dropped
drop_cnt  out  CNT_W  number of dropped events
commit_cnt  out  CNT_W  number of events accepted into FIFO

Behaviour:
- Reset (async, reset_n=0):
  - Read/write pointers and count cleared.
  - out_valid=0; all out_* data fields 0.
  - overflow=0, drop_cnt=0, commit_cnt=0.
  - FIFO storage is not cleared.
  - Reset asserted mid-stream discards all buffered entries immediately; no partial entry is emitted after deassertion.
- Event qualification per cycle:
  - E_wb = wb_valid & (wb_rd != 0). Writes to x0 are never recorded, dropped or counted.
  - E_st = st_valid.
  - E_br = br_valid.
- Ordering: qualified events are enqueued in age order WB, then ST, then BR. The order is fixed and holds regardless of which subset is active.
- Entry formation:
  - WB: type = wb_is_load ? 2 : 0. rd = wb_rd, value = wb_data. addr = wb_is_load ? wb_addr : 0.
  - ST: type 1, rd 0, value = st_data, addr = st_addr.
  - BR: type 3, rd, value and addr all 0.
- Capacity:
  - free = DEPTH - count, sampled at the start of the cycle. A pop in the same cycle does not add capacity until the next cycle.
  - The first min(free, n_events) qualified events in age order are written to consecutive slots.
  - Any remaining events are dropped: drop_cnt increments by the number dropped and overflow sets.
  - Up to 3 writes per cycle; write pointer wraps modulo DEPTH.
- Output:
  - Registered FWFT: out_* reflect the head entry. out_valid = (count != 0).
  - A pop occurs when out_valid & out_ready; the head advances one entry per cycle max. out_ready with empty FIFO has no effect.
  - Latency: an event presented in cycle N (FIFO empty) gives out_valid=1 with its data in cycle N+1.
- Simultaneous push and pop: count_next = count + n_written - pop. Must equal DEPTH exactly when full; never exceeds it.
- commit_cnt increments by n_written. Both counters saturate at all-ones.
- overflow and counters clear only on reset.

Test Plan:
- Single reg write: wb_valid=1, rd=5, data=0x0000002A, pc=0x00000010, instr=0x02A00293 -> next cycle out_valid=1, type 0, rd 5, value 0x2A; commit_cnt=1.
- x0 filter: wb_valid=1, rd=0 -> out_valid stays 0; commit_cnt=0, drop_cnt=0.
- Triple commit, out_ready=0: WB load (rd 6, 0x11, addr 0x100), store (addr 0x104, data 0x22) and branch (pc 0x40), all in one cycle -> three entries in order type 2, 1, 3; commit_cnt=3.
- Overflow: DEPTH=16, out_ready=0, 15 single pushes, then a cycle with WB+ST+BR -> only WB accepted; drop_cnt=2, overflow=1; count=16, and a further br_valid increments drop_cnt to 3.
- Full with concurrent pop: full FIFO, out_ready=1, st_valid=1 same cycle -> store dropped (free sampled as 0); count=15 next cycle; a store the following cycle is accepted.
- Reset mid-stream: 5 entries buffered, reset_n pulsed low asynchronously between clock edges -> out_valid=0 immediately, counters 0; after release, a new wb event appears as the sole entry.
